// File: rtl/audio_stereo_gain_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : audio_pkg
//  Description : Shared sample/frame types and saturation helper for the
//                stereo gain path.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 64;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    localparam logic signed [ACC_W-1:0] SAT_HI = 64'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_LO = -64'sd32768;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } frame_t;

    typedef struct packed {
        sample_t value;
        logic    clipped;
    } sat_t;

    // Clamp a wide signed value into the sample range and report clipping.
    function automatic sat_t saturate(input logic signed [ACC_W-1:0] v);
        sat_t r;
        if (v > SAT_HI) begin
            r.value   = SAMPLE_MAX;
            r.clipped = 1'b1;
        end else if (v < SAT_LO) begin
            r.value   = SAMPLE_MIN;
            r.clipped = 1'b1;
        end else begin
            r.value   = v[SAMPLE_W-1:0];
            r.clipped = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_stereo_gain_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface   : audio_stereo_gain_stage_if
//  Description : Left/right ADC and DAC valid/ready streams between the codec
//                core and the gain stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface audio_stereo_gain_stage_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] adc_left_data;
    logic                adc_left_valid;
    logic                adc_left_ready;
    logic [SAMPLE_W-1:0] adc_right_data;
    logic                adc_right_valid;
    logic                adc_right_ready;

    logic [SAMPLE_W-1:0] dac_left_data;
    logic                dac_left_valid;
    logic                dac_left_ready;
    logic [SAMPLE_W-1:0] dac_right_data;
    logic                dac_right_valid;
    logic                dac_right_ready;

    // Codec side
    modport master (
        output adc_left_data, adc_left_valid, adc_right_data, adc_right_valid,
        input  adc_left_ready, adc_right_ready,
        input  dac_left_data, dac_left_valid, dac_right_data, dac_right_valid,
        output dac_left_ready, dac_right_ready
    );

    // Gain stage side
    modport slave (
        input  adc_left_data, adc_left_valid, adc_right_data, adc_right_valid,
        output adc_left_ready, adc_right_ready,
        output dac_left_data, dac_left_valid, dac_right_data, dac_right_valid,
        input  dac_left_ready, dac_right_ready
    );

endinterface
`default_nettype wire

// File: rtl/audio_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : audio_frame_fifo
//  Description : Synchronous FIFO of stereo frames, MSB-wrap pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   push,
    input  frame_t      push_data,
    input  wire logic   pop,
    output frame_t      head,
    output logic        full,
    output logic        empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw:0] rd_ptr_q, rd_ptr_d;
    frame_t        mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);

    // A pop frees the head slot, so a push into a full FIFO is legal then.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign head = mem_q[rd_ptr_q[c_aw-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[c_aw-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_stereo_gain_stage.sv
`default_nettype none
// ============================================================================
//  Module      : audio_stereo_gain_stage
//  Description : Pairs L/R ADC samples, applies Q2.14 gain with saturation and
//                mute, buffers frames and returns them on the DAC streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_stereo_gain_stage
    import audio_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14
) (
    input  wire logic                   clk_clk,
    input  wire logic                   reset_reset_n,
    audio_stereo_gain_stage_if.slave    bus,
    input  wire logic [GAIN_W-1:0]      gain,
    input  wire logic                   mute,
    input  wire logic                   clip_clr,
    output logic                        clip_left,
    output logic                        clip_right
);

    localparam int c_prod_w = SAMPLE_W + GAIN_W + 1;

    // Signed sample times zero-extended gain, floor shift, then clamp.
    function automatic sat_t scale(input sample_t x, input logic [GAIN_W-1:0] g,
                                   input logic m);
        logic signed [GAIN_W:0]     gs;
        logic signed [c_prod_w-1:0] prod;
        logic signed [c_prod_w-1:0] shifted;
        sat_t                       r;
        gs      = {1'b0, g};
        prod    = x * gs;
        shifted = prod >>> GAIN_FRAC;
        r       = saturate(ACC_W'(shifted));
        if (m) begin
            r = '0;
        end
        return r;
    endfunction

    logic    left_full_q,   left_full_d;
    logic    right_full_q,  right_full_d;
    sample_t left_cap_q,    left_cap_d;
    sample_t right_cap_q,   right_cap_d;
    logic    stage_valid_q, stage_valid_d;
    frame_t  stage_frame_q, stage_frame_d;
    logic    left_sent_q,   left_sent_d;
    logic    right_sent_q,  right_sent_d;
    logic    clip_left_q,   clip_left_d;
    logic    clip_right_q,  clip_right_d;

    logic   w_left_in;
    logic   w_right_in;
    logic   w_left_out;
    logic   w_right_out;
    logic   w_fire;
    logic   w_drain;
    logic   w_pop;
    logic   w_fifo_full;
    logic   w_fifo_empty;
    frame_t w_head;
    sat_t   w_sat_l;
    sat_t   w_sat_r;

    assign w_left_in   = bus.adc_left_valid  && !left_full_q;
    assign w_right_in  = bus.adc_right_valid && !right_full_q;
    assign w_left_out  = bus.dac_left_valid  && bus.dac_left_ready;
    assign w_right_out = bus.dac_right_valid && bus.dac_right_ready;

    // The head frame leaves once each channel has been taken, in any order.
    assign w_pop   = !w_fifo_empty && (left_sent_q  || w_left_out)
                                   && (right_sent_q || w_right_out);
    assign w_drain = stage_valid_q && (!w_fifo_full || w_pop);
    assign w_fire  = left_full_q && right_full_q && (!stage_valid_q || w_drain);

    assign w_sat_l = scale(left_cap_q,  gain, mute);
    assign w_sat_r = scale(right_cap_q, gain, mute);

    assign bus.adc_left_ready  = !left_full_q;
    assign bus.adc_right_ready = !right_full_q;
    assign bus.dac_left_valid  = !w_fifo_empty && !left_sent_q;
    assign bus.dac_right_valid = !w_fifo_empty && !right_sent_q;
    assign bus.dac_left_data   = w_fifo_empty ? '0 : w_head.left;
    assign bus.dac_right_data  = w_fifo_empty ? '0 : w_head.right;
    assign clip_left           = clip_left_q;
    assign clip_right          = clip_right_q;

    always_comb begin
        left_full_d   = left_full_q;
        right_full_d  = right_full_q;
        left_cap_d    = left_cap_q;
        right_cap_d   = right_cap_q;
        stage_valid_d = stage_valid_q;
        stage_frame_d = stage_frame_q;
        left_sent_d   = left_sent_q;
        right_sent_d  = right_sent_q;
        clip_left_d   = clip_left_q;
        clip_right_d  = clip_right_q;

        if (w_left_in) begin
            left_full_d = 1'b1;
            left_cap_d  = bus.adc_left_data;
        end
        if (w_right_in) begin
            right_full_d = 1'b1;
            right_cap_d  = bus.adc_right_data;
        end

        if (w_fire) begin
            left_full_d         = 1'b0;
            right_full_d        = 1'b0;
            stage_valid_d       = 1'b1;
            stage_frame_d.left  = w_sat_l.value;
            stage_frame_d.right = w_sat_r.value;
        end else if (w_drain) begin
            stage_valid_d = 1'b0;
        end

        if (w_pop) begin
            left_sent_d  = 1'b0;
            right_sent_d = 1'b0;
        end else begin
            if (w_left_out) begin
                left_sent_d = 1'b1;
            end
            if (w_right_out) begin
                right_sent_d = 1'b1;
            end
        end

        // A clip arriving with clip_clr takes priority over the clear.
        if (clip_clr) begin
            clip_left_d  = 1'b0;
            clip_right_d = 1'b0;
        end
        if (w_fire && w_sat_l.clipped) begin
            clip_left_d = 1'b1;
        end
        if (w_fire && w_sat_r.clipped) begin
            clip_right_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            left_full_q   <= 1'b0;
            right_full_q  <= 1'b0;
            left_cap_q    <= '0;
            right_cap_q   <= '0;
            stage_valid_q <= 1'b0;
            stage_frame_q <= '0;
            left_sent_q   <= 1'b0;
            right_sent_q  <= 1'b0;
            clip_left_q   <= 1'b0;
            clip_right_q  <= 1'b0;
        end else begin
            left_full_q   <= left_full_d;
            right_full_q  <= right_full_d;
            left_cap_q    <= left_cap_d;
            right_cap_q   <= right_cap_d;
            stage_valid_q <= stage_valid_d;
            stage_frame_q <= stage_frame_d;
            left_sent_q   <= left_sent_d;
            right_sent_q  <= right_sent_d;
            clip_left_q   <= clip_left_d;
            clip_right_q  <= clip_right_d;
        end
    end

    audio_frame_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .push       (w_drain),
        .push_data  (stage_frame_q),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_audio_stereo_gain_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_stereo_gain_stage
//  Description : Self-checking bench: vector table, directed sequences and
//                randomized streams scored against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_audio_stereo_gain_stage;

    logic        clk_clk       = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [15:0] gain          = 16'h4000;
    logic        mute          = 1'b0;
    logic        clip_clr      = 1'b0;
    logic        clip_left;
    logic        clip_right;

    audio_stereo_gain_stage_if bus();

    audio_stereo_gain_stage #(
        .DEPTH     (4),
        .GAIN_W    (16),
        .GAIN_FRAC (14)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus),
        .gain          (gain),
        .mute          (mute),
        .clip_clr      (clip_clr),
        .clip_left     (clip_left),
        .clip_right    (clip_right)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] g;
        bit          m;
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] el;
        logic [15:0] er;
        bit          cl;
        bit          cr;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    logic [15:0] src_l[$], src_r[$], exp_l[$], exp_r[$];
    bit          exp_cl = 0, exp_cr = 0;
    int          out_l = 0, out_r = 0;
    logic [15:0] last_l = 0, last_r = 0;
    int          p_lv = 100, p_rv = 100, p_dl = 100, p_dr = 100;
    bit          hold_l = 0, hold_r = 0;
    logic [15:0] hold_l_data = 0, hold_r_data = 0;
    int          cap_r_step = -1, first_val_step = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: floor(x * g / 2^14), clamped to 16-bit signed; mute forces 0.
    function automatic logic [15:0] ref_out(input logic [15:0] x, input logic [15:0] g,
                                            input bit m, output bit clipped);
        longint xs, gl, p, q;
        clipped = 0;
        if (m) return 16'h0000;
        xs = longint'($signed(x));
        gl = longint'(g);
        p  = xs * gl;
        q  = p / 16384;
        if (p < 0 && (p % 16384) != 0) q = q - 1;
        if (q > 32767) begin
            q = 32767;
            clipped = 1;
        end else if (q < -32768) begin
            q = -32768;
            clipped = 1;
        end
        return 16'(q);
    endfunction

    task automatic score();
        bit          c;
        logic [15:0] y;
        if (bus.adc_left_valid && bus.adc_left_ready) begin
            y = ref_out(src_l[0], gain, mute, c);
            exp_l.push_back(y);
            exp_cl = exp_cl | c;
            void'(src_l.pop_front());
        end
        if (bus.adc_right_valid && bus.adc_right_ready) begin
            y = ref_out(src_r[0], gain, mute, c);
            exp_r.push_back(y);
            exp_cr = exp_cr | c;
            void'(src_r.pop_front());
            if (cap_r_step < 0) cap_r_step = step;
        end
        if (bus.dac_left_valid && first_val_step < 0) first_val_step = step;

        if (hold_l) begin
            check("left_valid_held", {31'b0, bus.dac_left_valid}, 32'd1);
            check("left_data_stable", {16'b0, bus.dac_left_data}, {16'b0, hold_l_data});
        end
        if (hold_r) begin
            check("right_valid_held", {31'b0, bus.dac_right_valid}, 32'd1);
            check("right_data_stable", {16'b0, bus.dac_right_data}, {16'b0, hold_r_data});
        end
        hold_l = 0;
        hold_r = 0;
        if (bus.dac_left_valid) begin
            if (bus.dac_left_ready) begin
                if (exp_l.size() == 0) check("left_unexpected_frame", {16'b0, bus.dac_left_data}, 32'hFFFF_FFFF);
                else                   check("left_data", {16'b0, bus.dac_left_data}, {16'b0, exp_l.pop_front()});
                out_l++;
                last_l = bus.dac_left_data;
            end else begin
                hold_l = 1;
                hold_l_data = bus.dac_left_data;
            end
        end
        if (bus.dac_right_valid) begin
            if (bus.dac_right_ready) begin
                if (exp_r.size() == 0) check("right_unexpected_frame", {16'b0, bus.dac_right_data}, 32'hFFFF_FFFF);
                else                   check("right_data", {16'b0, bus.dac_right_data}, {16'b0, exp_r.pop_front()});
                out_r++;
                last_r = bus.dac_right_data;
            end else begin
                hold_r = 1;
                hold_r_data = bus.dac_right_data;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, sample, then advance one cycle.
    task automatic cyc();
        bus.adc_left_valid  = (src_l.size() > 0) && ($urandom_range(99) < p_lv);
        bus.adc_left_data   = (src_l.size() > 0) ? src_l[0] : 16'h0000;
        bus.adc_right_valid = (src_r.size() > 0) && ($urandom_range(99) < p_rv);
        bus.adc_right_data  = (src_r.size() > 0) ? src_r[0] : 16'h0000;
        bus.dac_left_ready  = ($urandom_range(99) < p_dl);
        bus.dac_right_ready = ($urandom_range(99) < p_dr);
        #1;
        score();
        step++;
        @(negedge clk_clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src_l.size() + src_r.size() + exp_l.size() + exp_r.size()) != 0 && n < budget) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout: %0d frames still pending after %0d cycles",
                     src_l.size() + exp_l.size(), n);
        end
    endtask

    task automatic pulse_clear();
        clip_clr = 1;
        cyc();
        clip_clr = 0;
        exp_cl = 0;
        exp_cr = 0;
        check("clip_left_after_clr", {31'b0, clip_left}, 32'd0);
        check("clip_right_after_clr", {31'b0, clip_right}, 32'd0);
    endtask

    function automatic logic [15:0] rnd_sample();
        case ($urandom_range(4))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'($urandom_range(15)) - 16'd8;
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t vecs[9];

    initial begin
        int base_l, base_r, n;

        vecs[0] = '{16'h4000, 0, 16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC, 0, 0};
        vecs[1] = '{16'h8000, 0, 16'h5000, 16'h9000, 16'h7FFF, 16'h8000, 1, 1};
        vecs[2] = '{16'h2000, 0, 16'hFFFD, 16'h0005, 16'hFFFE, 16'h0002, 0, 0};
        vecs[3] = '{16'h8000, 1, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 0, 0};
        vecs[4] = '{16'hFFFF, 0, 16'h0001, 16'hFFFF, 16'h0003, 16'hFFFC, 0, 0};
        vecs[5] = '{16'h0000, 0, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 0, 0};
        vecs[6] = '{16'h4001, 0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1, 1};
        vecs[7] = '{16'h4000, 0, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 0, 0};
        vecs[8] = '{16'h6000, 0, 16'h5555, 16'hAAAB, 16'h7FFF, 16'h8000, 0, 0};

        bus.adc_left_valid  = 0;
        bus.adc_left_data   = 0;
        bus.adc_right_valid = 0;
        bus.adc_right_data  = 0;
        bus.dac_left_ready  = 0;
        bus.dac_right_ready = 0;

        // Reset values
        repeat (3) @(negedge clk_clk);
        check("rst_adc_left_ready", {31'b0, bus.adc_left_ready}, 32'd1);
        check("rst_adc_right_ready", {31'b0, bus.adc_right_ready}, 32'd1);
        check("rst_dac_left_valid", {31'b0, bus.dac_left_valid}, 32'd0);
        check("rst_dac_right_valid", {31'b0, bus.dac_right_valid}, 32'd0);
        check("rst_dac_left_data", {16'b0, bus.dac_left_data}, 32'd0);
        check("rst_dac_right_data", {16'b0, bus.dac_right_data}, 32'd0);
        check("rst_clip_left", {31'b0, clip_left}, 32'd0);
        check("rst_clip_right", {31'b0, clip_right}, 32'd0);
        reset_reset_n = 1;

        // Latency: L first, R two cycles later, output three cycles after R capture
        gain = 16'h4000;
        cap_r_step = -1;
        first_val_step = -1;
        src_l.push_back(16'h1234);
        cyc();
        cyc();
        src_r.push_back(16'hEDCC);
        drain(40);
        check("latency_r_capture_to_valid", 32'(first_val_step - cap_r_step), 32'd3);
        check("latency_left_out", {16'b0, last_l}, 32'h1234);
        check("latency_right_out", {16'b0, last_r}, 32'hEDCC);

        // Vector table
        foreach (vecs[i]) begin
            pulse_clear();
            gain = vecs[i].g;
            mute = vecs[i].m;
            src_l.push_back(vecs[i].l);
            src_r.push_back(vecs[i].r);
            drain(40);
            check($sformatf("vec%0d_left", i), {16'b0, last_l}, {16'b0, vecs[i].el});
            check($sformatf("vec%0d_right", i), {16'b0, last_r}, {16'b0, vecs[i].er});
            check($sformatf("vec%0d_clip_left", i), {31'b0, clip_left}, {31'b0, vecs[i].cl});
            check($sformatf("vec%0d_clip_right", i), {31'b0, clip_right}, {31'b0, vecs[i].cr});
        end
        mute = 0;
        pulse_clear();

        // A clip in the same cycle as clip_clr must remain set
        gain = 16'h8000;
        src_l.push_back(16'h5000);
        src_r.push_back(16'h9000);
        cyc();
        clip_clr = 1;
        cyc();
        clip_clr = 0;
        drain(40);
        check("set_wins_clip_left", {31'b0, clip_left}, 32'd1);
        check("set_wins_clip_right", {31'b0, clip_right}, 32'd1);
        pulse_clear();

        // Backpressure: 7 pairs offered, only 6 fit (4 FIFO + stage + capture)
        gain = 16'h4000;
        p_dl = 0;
        p_dr = 0;
        base_l = out_l;
        for (int i = 0; i < 7; i++) begin
            src_l.push_back(16'(16'h1111 * (i + 1)));
            src_r.push_back(16'(16'h0F0F * (i + 2)));
        end
        repeat (20) cyc();
        check("bp_left_pending", 32'(src_l.size()), 32'd1);
        check("bp_right_pending", 32'(src_r.size()), 32'd1);
        check("bp_adc_left_ready", {31'b0, bus.adc_left_ready}, 32'd0);
        check("bp_adc_right_ready", {31'b0, bus.adc_right_ready}, 32'd0);
        check("bp_dac_left_valid", {31'b0, bus.dac_left_valid}, 32'd1);
        p_dl = 100;
        p_dr = 100;
        drain(100);
        check("bp_frames_out", 32'(out_l - base_l), 32'd7);

        // Split accept: left taken, right held off for 5 cycles
        p_dr = 0;
        base_l = out_l;
        base_r = out_r;
        for (int i = 0; i < 2; i++) begin
            src_l.push_back(16'(16'h0100 + i));
            src_r.push_back(16'(16'hF100 + i));
        end
        n = 0;
        while (out_l == base_l && n < 20) begin
            cyc();
            n++;
        end
        check("split_left_taken", 32'(out_l - base_l), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("split_left_valid_low", {31'b0, bus.dac_left_valid}, 32'd0);
            check("split_right_valid_high", {31'b0, bus.dac_right_valid}, 32'd1);
            check("split_right_data", {16'b0, bus.dac_right_data}, 32'hF100);
            cyc();
        end
        check("split_no_pop_left", 32'(out_l - base_l), 32'd1);
        check("split_no_pop_right", 32'(out_r - base_r), 32'd0);
        p_dr = 100;
        drain(60);
        check("split_total_left", 32'(out_l - base_l), 32'd2);
        check("split_total_right", 32'(out_r - base_r), 32'd2);

        // Reset mid-stream: 3 buffered frames plus one captured left sample
        p_dl = 0;
        p_dr = 0;
        for (int i = 0; i < 3; i++) begin
            src_l.push_back(16'(16'h2220 + i));
            src_r.push_back(16'(16'h3330 + i));
        end
        src_l.push_back(16'h4444);
        repeat (12) cyc();
        check("rstmid_pre_valid", {31'b0, bus.dac_left_valid}, 32'd1);
        check("rstmid_pre_left_full", {31'b0, bus.adc_left_ready}, 32'd0);
        reset_reset_n = 0;
        bus.adc_left_valid  = 0;
        bus.adc_right_valid = 0;
        src_l.delete();
        src_r.delete();
        exp_l.delete();
        exp_r.delete();
        hold_l = 0;
        hold_r = 0;
        exp_cl = 0;
        exp_cr = 0;
        @(posedge clk_clk);
        #1;
        check("rstmid_dac_left_valid", {31'b0, bus.dac_left_valid}, 32'd0);
        check("rstmid_dac_right_valid", {31'b0, bus.dac_right_valid}, 32'd0);
        check("rstmid_adc_left_ready", {31'b0, bus.adc_left_ready}, 32'd1);
        check("rstmid_adc_right_ready", {31'b0, bus.adc_right_ready}, 32'd1);
        check("rstmid_dac_left_data", {16'b0, bus.dac_left_data}, 32'd0);
        @(negedge clk_clk);
        reset_reset_n = 1;
        p_dl = 100;
        p_dr = 100;
        base_l = out_l;
        base_r = out_r;
        repeat (10) cyc();
        check("rstmid_no_stale_left", 32'(out_l - base_l), 32'd0);
        check("rstmid_no_stale_right", 32'(out_r - base_r), 32'd0);

        // Randomized streams against the reference model
        for (int round = 0; round < 6; round++) begin
            case (round % 3)
                0:       gain = 16'h4000;
                1:       gain = 16'($urandom);
                default: gain = 16'($urandom_range(16'hFFFF, 16'h8000));
            endcase
            mute = (round == 4);
            pulse_clear();
            p_lv = $urandom_range(100, 30);
            p_rv = $urandom_range(100, 30);
            p_dl = $urandom_range(100, 30);
            p_dr = $urandom_range(100, 30);
            for (int i = 0; i < 25; i++) begin
                src_l.push_back(rnd_sample());
                src_r.push_back(rnd_sample());
            end
            drain(1500);
            check($sformatf("rnd%0d_clip_left", round), {31'b0, clip_left}, {31'b0, exp_cl});
            check($sformatf("rnd%0d_clip_right", round), {31'b0, clip_right}, {31'b0, exp_cr});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
